mmult_result_collector: RTL and testbench
=========================================

Name: mmult_result_collector

Overview:
- Sits directly downstream of the mmult engine and sequences one X(mxn)*Y(nx1) column pass.
- Pulses mmult_start, then captures each per-datapoint result into an internal m-entry buffer.
- Once all m results are in, streams them out in row order over a valid/ready handshake to the next layer or output DMA stage.
- mmult's done flags are sticky, so the block qualifies them on rising edges and owns its own row count for completion.

Parameters:
- width, 8, bit width of each result word.
- m, 64, results per pass (rows of X); legal range m >= 1.
- n, 8, inner dimension of the matching mmult; legal range n >= 2, so that successive datapoint_done pulses are separated by at least one low cycle.
- CLAMP_MAX, 8'hFF, saturation ceiling; used only with RESULT_CLAMP_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle request to run one pass; ignored unless IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse after the final output transfer
- spurious_err  out  1  sticky: a datapoint_done rising edge arrived outside COLLECT or after m captures; cleared by an accepted start
- mmult_start  out  1  1-cycle pulse to mmult
- mmult_particular_datapoint_done  in  1  from mmult, level, may stay high between passes
- mmult_results  in  width  from mmult, valid in the same cycle datapoint_done rises
- out_data  out  width  registered result word
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts
- out_last  out  1  qualifies the final word (row m-1)

Behaviour:
- Reset values: busy=0, done=0, spurious_err=0, mmult_start=0, out_valid=0, out_last=0, out_data=0, row_cnt=0, rd_ptr=0, dd_prev=0, state=IDLE. Buffer contents are not reset.
- Edge detect: dd_prev registers mmult_particular_datapoint_done every cycle. cap = datapoint_done & ~dd_prev.
- FSM states: IDLE, LAUNCH, COLLECT, DRAIN, DONE.
- IDLE:
  - start=1 moves to LAUNCH and clears row_cnt, rd_ptr and spurious_err.
  - In the same cycle, dd_prev is loaded with the current datapoint_done, so a stale high level from the previous pass is never counted.
- LAUNCH: mmult_start=1 for exactly this one cycle, then COLLECT.
- COLLECT:
  - On cap, buf[row_cnt] <= mmult_results and row_cnt++.
  - When the capture makes row_cnt == m, the next state is DRAIN.
  - The DRAIN entry edge also loads out_data=buf[0], out_valid=1, and out_last=(m==1).
  - The word captured on the final edge is bypassed straight into out_data when m==1.
- DRAIN:
  - A transfer occurs when out_valid & out_ready.
  - On a transfer with rd_ptr < m-1: rd_ptr++, out_data <= buf[rd_ptr+1], and out_last <= (rd_ptr+1 == m-1).
  - On a transfer with out_last=1: out_valid <= 0, out_last <= 0, next state DONE.
  - While out_ready=0: out_data, out_valid and out_last hold stable.
- DONE: done=1 for one cycle, then IDLE.
- Latency:
  - Last capture edge to out_valid high: 1 cycle.
  - Last transfer to done: 1 cycle.
  - Minimum pass length: 2 + (collect time) + m + 1 cycles with out_ready held high.
- Width rule: results are stored and emitted unmodified at width bits; no arithmetic in the default build.
- Boundary conditions:
  - cap in IDLE, LAUNCH, DRAIN or DONE: data discarded, spurious_err <= 1.
  - row_cnt never exceeds m.
  - start while busy: ignored, no effect on state or flags.
  - out_ready high while out_valid is low: no effect.
  - reset mid-pass, in any state: returns to IDLE with all reset values next cycle. The block does not reset mmult; any late datapoint_done edges seen in IDLE set spurious_err, which the next accepted start clears.
- Counter widths: row_cnt and rd_ptr are $clog2(m)+1 bits, so the value m is representable.

Optional Feature:
- Macro: RESULT_CLAMP_EN.
- Defined: the captured word is min(mmult_results, CLAMP_MAX), applied at the buffer write. out_data never exceeds CLAMP_MAX. No change in latency.
- Undefined: no compare logic; captured words pass through unmodified; CLAMP_MAX is unused.

Test Plan:
- Basic pass: m=4, n=2, out_ready=1; model edges with results 10,20,30,40 -> one mmult_start pulse 1 cycle after start; out_data 10,20,30,40 on consecutive cycles; out_last only on 40; done 1 cycle after that transfer.
- Sticky level: datapoint_done held at 1 from the prior pass when start arrives -> no capture until it drops and re-rises; exactly 4 captures; spurious_err=0.
- Backpressure: out_ready toggles 1,0,0,1,0,1,1 during DRAIN -> data/valid/last stable while low; order 10,20,30,40 preserved; no duplicates or drops.
- Spurious edge and ignored start: datapoint_done edge in IDLE -> spurious_err=1; next start clears it. A start pulse during COLLECT -> no second mmult_start, row_cnt unaffected.
- Reset mid-DRAIN: reset asserted after 2 transfers -> next cycle out_valid=0, busy=0, state IDLE; a new pass then emits all 4 fresh words.
- Clamp, with RESULT_CLAMP_EN defined and CLAMP_MAX=8'd100: inputs 50,150,100,255 -> outputs 50,100,100,100. Without the macro -> outputs 50,150,100,255.

Source files
------------

// File: rtl/mmult_result_collector.sv
// mmult_result_collector: runs one mmult column pass, buffers m results, then streams them out in row order; define RESULT_CLAMP_EN to saturate captured words at CLAMP_MAX
module mmult_result_collector #(
  parameter int width = 8,
  parameter int m = 64,
  parameter int n = 8,
  parameter logic [width-1:0] CLAMP_MAX = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             spurious_err,
  output logic             mmult_start,
  input  logic             mmult_particular_datapoint_done,
  input  logic [width-1:0] mmult_results,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);
  localparam int cw = $clog2(m) + 1;
  localparam int aw = m > 1 ? $clog2(m) : 1;
  localparam logic [cw-1:0] m_c = cw'(m);
  localparam logic [cw-1:0] last_c = cw'(m - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, COLLECT, DRAIN, DONE} state_t;
  state_t state;
  logic [width-1:0] mem [m];
  logic [width-1:0] wr_data;
  logic [cw-1:0] row_cnt, rd_ptr, rd_nxt;
  logic dd_prev, cap, wr_en, unused_cfg;
  assign cap = mmult_particular_datapoint_done & ~dd_prev;
  assign wr_en = cap && state == COLLECT && row_cnt != m_c;
  assign rd_nxt = rd_ptr + cw'(1);
  assign unused_cfg = ^{CLAMP_MAX, n[0]};
`ifdef RESULT_CLAMP_EN
  assign wr_data = mmult_results > CLAMP_MAX ? CLAMP_MAX : mmult_results;
`else
  assign wr_data = mmult_results;
`endif
  // result buffer, written on each qualified datapoint_done rising edge
  always_ff @(posedge clk) if (wr_en) mem[row_cnt[aw-1:0]] <= wr_data;
  // pass sequencer: launch, collect m results, drain with backpressure, signal completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      spurious_err <= 1'b0;
      mmult_start <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      row_cnt <= '0;
      rd_ptr <= '0;
      dd_prev <= 1'b0;
    end else begin
      dd_prev <= mmult_particular_datapoint_done;
      mmult_start <= 1'b0;
      done <= 1'b0;
      if (cap && (state != COLLECT || row_cnt == m_c)) spurious_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= LAUNCH;
          busy <= 1'b1;
          mmult_start <= 1'b1;
          row_cnt <= '0;
          rd_ptr <= '0;
          spurious_err <= 1'b0;
        end
        LAUNCH: state <= COLLECT;
        COLLECT: if (wr_en) begin
          row_cnt <= row_cnt + cw'(1);
          if (row_cnt == last_c) begin
            state <= DRAIN;
            out_data <= m == 1 ? wr_data : mem[0];
            out_valid <= 1'b1;
            out_last <= m == 1;
          end
        end
        DRAIN: if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            rd_ptr <= rd_nxt;
            out_data <= mem[rd_nxt[aw-1:0]];
            out_last <= rd_nxt == last_c;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmult_result_collector.sv
// tb_mmult_result_collector: directed bench for the result collector with m=4, n=2
module tb_mmult_result_collector;
  logic clk = 1'b0;
  logic reset, start, dd, out_ready;
  logic busy, done, spurious_err, mmult_start, out_valid, out_last;
  logic [7:0] res, out_data;
  int tests = 0;
  int fails = 0;
  logic [7:0] got[$];
  int xc[$];
  int n_last, last_idx, done_cyc, unstable;

  always #5 clk = ~clk;

  mmult_result_collector #(.width(8), .m(4), .n(2), .CLAMP_MAX(8'd100)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .spurious_err(spurious_err),
    .mmult_start(mmult_start),
    .mmult_particular_datapoint_done(dd),
    .mmult_results(res),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last)
  );

  function automatic logic [31:0] words();
    return got.size() == 4 ? {got[0], got[1], got[2], got[3]} : 32'hxxxxxxxx;
  endfunction

  task automatic feed(input logic [7:0] v, input bit hold);
    dd = 1'b1;
    res = v;
    @(negedge clk);
    if (!hold) dd = 1'b0;
    res = 8'hEE;
  endtask

  task automatic feed4(input logic [31:0] v, input bit hold);
    for (int i = 0; i < 4; i++) begin
      feed(v[31-8*i -: 8], hold && i == 3);
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic start_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_drain(input logic [6:0] pat);
    logic pv, pl, stall;
    logic [7:0] pd;
    got.delete();
    xc.delete();
    n_last = 0;
    last_idx = -1;
    done_cyc = -1;
    unstable = 0;
    stall = 1'b0;
    pv = 1'b0;
    pl = 1'b0;
    pd = '0;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      out_ready = c < 7 ? pat[6-c] : 1'b1;
      if (stall && {out_valid, out_last, out_data} !== {pv, pl, pd}) unstable++;
      if (done) done_cyc = c;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        xc.push_back(c);
        if (out_last) begin
          n_last++;
          last_idx = got.size() - 1;
        end
      end
      stall = out_valid && !out_ready;
      pv = out_valid;
      pl = out_last;
      pd = out_data;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dd = 1'b0;
    res = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, spurious_err, mmult_start, out_valid, out_last} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 000000", {busy, done, spurious_err, mmult_start, out_valid, out_last});
    end
    tests++;
    if (out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %h expected 00", out_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({mmult_start, busy} !== 2'b11) begin
      fails++;
      $display("FAIL basic_launch: got mmult_start,busy=%b expected 11", {mmult_start, busy});
    end
    @(negedge clk);
    tests++;
    if (mmult_start !== 1'b0) begin
      fails++;
      $display("FAIL basic_start_pulse_width: got %b expected 0", mmult_start);
    end
    feed4(32'h0A141E28, 1'b1);
    run_drain(7'b1111111);
    tests++;
    if (words() !== 32'h0A141E28) begin
      fails++;
      $display("FAIL basic_words: got %h expected 0a141e28", words());
    end
    tests++;
    if (xc.size() != 4 || xc[0] != 0 || xc[3] != 3) begin
      fails++;
      $display("FAIL basic_timing: got %0d transfers expected 4 at cycles 0..3", xc.size());
    end
    tests++;
    if (n_last != 1 || last_idx != 3) begin
      fails++;
      $display("FAIL basic_last: got count %0d idx %0d expected 1 3", n_last, last_idx);
    end
    tests++;
    if (done_cyc != 4) begin
      fails++;
      $display("FAIL basic_done: got cycle %0d expected 4", done_cyc);
    end
    tests++;
    if ({busy, spurious_err} !== 2'b00) begin
      fails++;
      $display("FAIL basic_idle: got busy,err=%b expected 00", {busy, spurious_err});
    end
  endtask

  task automatic test_sticky();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res = 8'h99;
    repeat (2) @(negedge clk);
    dd = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL sticky_no_early_valid: got %b expected 0", out_valid);
    end
    feed4(32'h01020304, 1'b0);
    run_drain(7'b1111111);
    tests++;
    if (words() !== 32'h01020304) begin
      fails++;
      $display("FAIL sticky_words: got %h expected 01020304", words());
    end
    tests++;
    if (spurious_err !== 1'b0) begin
      fails++;
      $display("FAIL sticky_err: got %b expected 0", spurious_err);
    end
  endtask

  task automatic test_backpressure();
    start_pass();
    feed4(32'h0A141E28, 1'b0);
    run_drain(7'b1001011);
    tests++;
    if (words() !== 32'h0A141E28) begin
      fails++;
      $display("FAIL bp_words: got %h expected 0a141e28", words());
    end
    tests++;
    if (xc.size() != 4 || xc[0] != 0 || xc[1] != 3 || xc[2] != 5 || xc[3] != 6) begin
      fails++;
      $display("FAIL bp_timing: got %0d transfers expected cycles 0,3,5,6", xc.size());
    end
    tests++;
    if (unstable != 0) begin
      fails++;
      $display("FAIL bp_stable: got %0d changes while stalled expected 0", unstable);
    end
    tests++;
    if (done_cyc != 7 || n_last != 1 || last_idx != 3) begin
      fails++;
      $display("FAIL bp_done_last: got done %0d last %0d/%0d expected 7 1/3", done_cyc, n_last, last_idx);
    end
  endtask

  task automatic test_spurious_and_start();
    dd = 1'b1;
    @(negedge clk);
    dd = 1'b0;
    @(negedge clk);
    tests++;
    if (spurious_err !== 1'b1) begin
      fails++;
      $display("FAIL spurious_set: got %b expected 1", spurious_err);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({spurious_err, mmult_start} !== 2'b01) begin
      fails++;
      $display("FAIL spurious_clear: got err,mmult_start=%b expected 01", {spurious_err, mmult_start});
    end
    @(negedge clk);
    feed(8'h21, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({mmult_start, busy} !== 2'b01) begin
      fails++;
      $display("FAIL busy_start_ignored: got mmult_start,busy=%b expected 01", {mmult_start, busy});
    end
    feed(8'h22, 1'b0);
    @(negedge clk);
    feed(8'h23, 1'b0);
    @(negedge clk);
    feed(8'h24, 1'b0);
    run_drain(7'b1111111);
    tests++;
    if (words() !== 32'h21222324 || spurious_err !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_words: got %h err %b expected 21222324 err 0", words(), spurious_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    start_pass();
    feed4(32'h05060708, 1'b0);
    out_ready = 1'b1;
    tests++;
    if ({out_valid, out_data} !== 9'h105) begin
      fails++;
      $display("FAIL rst_first_word: got %h expected 105", {out_valid, out_data});
    end
    @(negedge clk);
    tests++;
    if (out_data !== 8'h06) begin
      fails++;
      $display("FAIL rst_second_word: got %h expected 06", out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, busy, out_last, out_data} !== 11'h000) begin
      fails++;
      $display("FAIL rst_mid_drain: got %h expected 000", {out_valid, busy, out_last, out_data});
    end
    reset = 1'b0;
    @(negedge clk);
    start_pass();
    feed4(32'h11121314, 1'b0);
    run_drain(7'b1111111);
    tests++;
    if (words() !== 32'h11121314) begin
      fails++;
      $display("FAIL rst_new_pass: got %h expected 11121314", words());
    end
  endtask

  task automatic test_clamp();
    logic [31:0] exp;
`ifdef RESULT_CLAMP_EN
    exp = 32'h32646464;
`else
    exp = 32'h329664FF;
`endif
    start_pass();
    feed4(32'h329664FF, 1'b0);
    run_drain(7'b1111111);
    tests++;
    if (words() !== exp) begin
      fails++;
      $display("FAIL clamp_words: got %h expected %h", words(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sticky();
    test_backpressure();
    test_spurious_and_start();
    test_reset_mid_drain();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
